// File: rtl/trng_arbiter_ctrl.sv
// Round-robin two-port sequencer for the dual-base TRNG sampler (reset, calibrate, read, deliver).
// Optional macro TRNG_REPCHECK_EN: discard any word equal to the previously accepted one.
module trng_arbiter_ctrl #(
    parameter logic [31:0] CALIB_CYCLES = 32'd1024,
    parameter int unsigned TRST_CYCLES  = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEn,
    input  logic [1:0]  iReq,
    input  logic [1:0]  iReq_base,
    output logic [1:0]  oValid,
    output logic [31:0] oData,
    output logic        oBusy,
    output logic        oTrng_en,
    output logic        oTrng_rst,
    output logic        oCalib,
    output logic [31:0] oCalib_cycles,
    output logic        oSel_base,
    output logic        oRead,
    input  logic        iTrng_ready,
    input  logic [31:0] iTrng_random
);
    localparam int CNT_W = (TRST_CYCLES > 1) ? $clog2(TRST_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_OFF, S_IDLE, S_TRST, S_CALIB, S_CALWAIT,
        S_RDPULSE, S_WAITLO, S_WAITHI, S_DELIVER
    } state_t;

    state_t           state_reg, state_next;
    logic             cal_valid_reg, cal_valid_next;
    logic             cur_base_reg, cur_base_next;
    logic             gnt_reg, gnt_next;
    logic             rr_last_reg, rr_last_next;
    logic [CNT_W-1:0] trst_cnt_reg, trst_cnt_next;
    logic [31:0]      word_reg, word_next;
    logic             grant_sel;
`ifdef TRNG_REPCHECK_EN
    logic [31:0]      last_word_reg, last_word_next;
    logic             last_word_ok_reg, last_word_ok_next;
`endif

    always_comb begin
        state_next     = state_reg;
        cal_valid_next = cal_valid_reg;
        cur_base_next  = cur_base_reg;
        gnt_next       = gnt_reg;
        rr_last_next   = rr_last_reg;
        trst_cnt_next  = trst_cnt_reg;
        word_next      = word_reg;
`ifdef TRNG_REPCHECK_EN
        last_word_next    = last_word_reg;
        last_word_ok_next = last_word_ok_reg;
`endif
        // With both ports asking, the one not served last wins.
        grant_sel = (&iReq) ? ~rr_last_reg : iReq[1];

        if (!iEn) begin
            state_next     = S_OFF;
            cal_valid_next = 1'b0;
`ifdef TRNG_REPCHECK_EN
            last_word_ok_next = 1'b0;
`endif
        end else begin
            case (state_reg)
                S_OFF: state_next = S_IDLE;
                S_IDLE: begin
                    if (|iReq) begin
                        gnt_next     = grant_sel;
                        rr_last_next = grant_sel;
                        if (cal_valid_reg && (iReq_base[grant_sel] == cur_base_reg)) begin
                            state_next = S_RDPULSE;
                        end else begin
                            // Base is only latched by the sampler at calibration.
                            state_next     = S_TRST;
                            trst_cnt_next  = '0;
                            cur_base_next  = iReq_base[grant_sel];
                            cal_valid_next = 1'b0;
`ifdef TRNG_REPCHECK_EN
                            last_word_ok_next = 1'b0;
`endif
                        end
                    end
                end
                S_TRST: begin
                    if (trst_cnt_reg == CNT_W'(TRST_CYCLES - 1))
                        state_next = S_CALIB;
                    else
                        trst_cnt_next = trst_cnt_reg + 1'b1;
                end
                S_CALIB: state_next = S_CALWAIT;
                S_CALWAIT: begin
                    if (iTrng_ready) begin
                        cal_valid_next = 1'b1;
                        state_next     = S_RDPULSE;
                    end
                end
                S_RDPULSE: state_next = S_WAITLO;
                S_WAITLO: begin
                    if (!iTrng_ready)
                        state_next = S_WAITHI;
                end
                S_WAITHI: begin
                    if (iTrng_ready) begin
`ifdef TRNG_REPCHECK_EN
                        if (last_word_ok_reg && (iTrng_random == last_word_reg)) begin
                            state_next = S_RDPULSE;
                        end else begin
                            last_word_next    = iTrng_random;
                            last_word_ok_next = 1'b1;
                            word_next         = iTrng_random;
                            state_next        = S_DELIVER;
                        end
`else
                        word_next  = iTrng_random;
                        state_next = S_DELIVER;
`endif
                    end
                end
                S_DELIVER: state_next = S_IDLE;
                default:   state_next = S_OFF;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg     <= S_OFF;
            cal_valid_reg <= 1'b0;
            cur_base_reg  <= 1'b0;
            gnt_reg       <= 1'b0;
            rr_last_reg   <= 1'b1;
            trst_cnt_reg  <= '0;
            word_reg      <= '0;
`ifdef TRNG_REPCHECK_EN
            last_word_reg    <= '0;
            last_word_ok_reg <= 1'b0;
`endif
            oValid    <= 2'b00;
            oBusy     <= 1'b0;
            oTrng_en  <= 1'b0;
            oTrng_rst <= 1'b0;
            oCalib    <= 1'b0;
            oRead     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cal_valid_reg <= cal_valid_next;
            cur_base_reg  <= cur_base_next;
            gnt_reg       <= gnt_next;
            rr_last_reg   <= rr_last_next;
            trst_cnt_reg  <= trst_cnt_next;
            word_reg      <= word_next;
`ifdef TRNG_REPCHECK_EN
            last_word_reg    <= last_word_next;
            last_word_ok_reg <= last_word_ok_next;
`endif
            oValid    <= (state_next == S_DELIVER) ? (gnt_next ? 2'b10 : 2'b01) : 2'b00;
            oBusy     <= (state_next != S_IDLE) && (state_next != S_OFF);
            oTrng_en  <= (state_next != S_OFF);
            oTrng_rst <= (state_next == S_OFF) || (state_next == S_TRST);
            oCalib    <= (state_next == S_CALIB);
            oRead     <= (state_next == S_RDPULSE);
        end
    end

    assign oData         = word_reg;
    assign oSel_base     = cur_base_reg;
    assign oCalib_cycles = CALIB_CYCLES;

endmodule
